multicycle_control: RTL and testbench

//  Multi-cycle MIPS control unit: decodes opcode/funct (RTYPE, ADDI, LW, SW, BEQ) via a state machine instead of one combinational step.

---
 rtl/multicycle_control.sv | 201 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM with req/ready memory handshake and bounded wait timeout.
// Optional JUMP support is enabled by defining CONTROL_JUMP_EN.
module multicycle_control #(
  parameter int unsigned ALU_OP_WIDTH = 4,
  parameter int unsigned TIMEOUT_W    = 4,
  parameter int unsigned MEM_TIMEOUT  = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [5:0]              i_opcode,
  input  logic [5:0]              i_funct,
  input  logic                    i_alu_zero,
  input  logic                    i_mem_ready,
  output logic [ALU_OP_WIDTH-1:0] o_alu_op,
  output logic                    o_alu_src_a,
  output logic [1:0]              o_alu_src_b,
  output logic                    o_iord,
  output logic                    o_mem_req,
  output logic                    o_mem_we,
  output logic                    o_ir_load,
  output logic                    o_pc_load,
  output logic [1:0]              o_pc_src,
  output logic                    o_rd_addr_sel,
  output logic                    o_rd_data_sel,
  output logic                    o_rd_en,
  output logic                    o_bus_err
);

  localparam logic [3:0] ALU_OP_AND = 4'd0;
  localparam logic [3:0] ALU_OP_OR  = 4'd1;
  localparam logic [3:0] ALU_OP_ADD = 4'd2;
  localparam logic [3:0] ALU_OP_SUB = 4'd6;
  localparam logic [3:0] ALU_OP_SLT = 4'd7;

  localparam logic [5:0] OPCODE_RTYPE = 6'h00;
  localparam logic [5:0] OPCODE_J     = 6'h02;
  localparam logic [5:0] OPCODE_BEQ   = 6'h04;
  localparam logic [5:0] OPCODE_ADDI  = 6'h08;
  localparam logic [5:0] OPCODE_LW    = 6'h23;
  localparam logic [5:0] OPCODE_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  localparam logic [TIMEOUT_W-1:0] TimeoutCnt = TIMEOUT_W'(MEM_TIMEOUT);

  typedef enum logic [3:0] {
    StFetch, StDecode, StExec, StAluWb, StIExec, StIWb,
    StMemAdr, StMemRd, StMemWb, StMemWr, StBranch, StJump
  } state_e;

  state_e               r_state;
  logic [TIMEOUT_W-1:0] r_wait_cnt;
  logic                 r_bus_err;

  logic       w_mem_done;
  logic       w_timeout;
  logic [3:0] w_alu_op;

  assign w_mem_done = o_mem_req & i_mem_ready;
  assign w_timeout  = o_mem_req & ~i_mem_ready & (r_wait_cnt == TimeoutCnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StFetch;
      r_wait_cnt <= '0;
      r_bus_err  <= 1'b0;
    end else begin
      r_bus_err <= 1'b0;
      // Count only while a request is stalled; any completion or idle state keeps it at zero
      if (o_mem_req && !w_mem_done && !w_timeout) begin
        r_wait_cnt <= r_wait_cnt + TIMEOUT_W'(1);
      end else begin
        r_wait_cnt <= '0;
      end

      if (w_timeout) begin
        r_state   <= StFetch;
        r_bus_err <= 1'b1;
      end else begin
        unique case (r_state)
          StFetch: if (i_mem_ready) r_state <= StDecode;
          StDecode: begin
            case (i_opcode)
              OPCODE_RTYPE: r_state <= StExec;
              OPCODE_ADDI:  r_state <= StIExec;
              OPCODE_LW,
              OPCODE_SW:    r_state <= StMemAdr;
              OPCODE_BEQ:   r_state <= StBranch;
`ifdef CONTROL_JUMP_EN
              OPCODE_J:     r_state <= StJump;
`endif
              default: begin
                r_state   <= StFetch;
                r_bus_err <= 1'b1;
              end
            endcase
          end
          StExec:   r_state <= StAluWb;
          StAluWb:  r_state <= StFetch;
          StIExec:  r_state <= StIWb;
          StIWb:    r_state <= StFetch;
          StMemAdr: r_state <= (i_opcode == OPCODE_LW) ? StMemRd : StMemWr;
          StMemRd:  if (i_mem_ready) r_state <= StMemWb;
          StMemWb:  r_state <= StFetch;
          StMemWr:  if (i_mem_ready) r_state <= StFetch;
          StBranch: r_state <= StFetch;
`ifdef CONTROL_JUMP_EN
          StJump:   r_state <= StFetch;
`endif
          default: begin
            r_state   <= StFetch;
            r_bus_err <= 1'b1;
          end
        endcase
      end
    end
  end

  always_comb begin
    w_alu_op      = ALU_OP_AND;
    o_alu_src_a   = 1'b0;
    o_alu_src_b   = 2'd0;
    o_iord        = 1'b0;
    o_mem_req     = 1'b0;
    o_mem_we      = 1'b0;
    o_ir_load     = 1'b0;
    o_pc_load     = 1'b0;
    o_pc_src      = 2'd0;
    o_rd_addr_sel = 1'b0;
    o_rd_data_sel = 1'b0;
    o_rd_en       = 1'b0;
    unique case (r_state)
      StFetch: begin
        o_mem_req   = 1'b1;
        o_alu_src_b = 2'd1;
        w_alu_op    = ALU_OP_ADD;
        o_ir_load   = i_mem_ready;
        o_pc_load   = i_mem_ready;
      end
      StDecode: begin
        o_alu_src_b = 2'd3;
        w_alu_op    = ALU_OP_ADD;
      end
      StExec: begin
        o_alu_src_a = 1'b1;
        case (i_funct)
          FUNCT_ADD: w_alu_op = ALU_OP_ADD;
          FUNCT_SUB: w_alu_op = ALU_OP_SUB;
          FUNCT_AND: w_alu_op = ALU_OP_AND;
          FUNCT_OR:  w_alu_op = ALU_OP_OR;
          FUNCT_SLT: w_alu_op = ALU_OP_SLT;
          default:   w_alu_op = ALU_OP_AND;
        endcase
      end
      StAluWb: begin
        o_rd_en       = 1'b1;
        o_rd_addr_sel = 1'b1;
      end
      StIExec, StMemAdr: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = 2'd2;
        w_alu_op    = ALU_OP_ADD;
      end
      StIWb: o_rd_en = 1'b1;
      StMemRd: begin
        o_mem_req = 1'b1;
        o_iord    = 1'b1;
      end
      StMemWb: begin
        o_rd_en       = 1'b1;
        o_rd_data_sel = 1'b1;
      end
      StMemWr: begin
        o_mem_req = 1'b1;
        o_mem_we  = 1'b1;
        o_iord    = 1'b1;
      end
      StBranch: begin
        o_alu_src_a = 1'b1;
        w_alu_op    = ALU_OP_SUB;
        o_pc_src    = 2'd1;
        o_pc_load   = i_alu_zero;
      end
`ifdef CONTROL_JUMP_EN
      StJump: begin
        o_pc_load = 1'b1;
        o_pc_src  = 2'd2;
      end
`endif
      default: ;
    endcase
  end

  assign o_alu_op  = ALU_OP_WIDTH'(w_alu_op);
  assign o_bus_err = r_bus_err;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected cycle traces built from the
// instruction semantics, with randomized memory waits, driven and compared cycle by cycle.
module tb_multicycle_control;

  localparam logic [3:0] A_AND = 4'd0, A_OR = 4'd1, A_ADD = 4'd2, A_SUB = 4'd6, A_SLT = 4'd7;
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam int MEM_TO = 15;

  // Output vector layout: alu_op, src_a, src_b, iord, req, we, ir_load, pc_load, pc_src,
  // rd_addr_sel, rd_data_sel, rd_en
  localparam logic [16:0] M_OP = 17'h1E000, M_A = 17'h01000, M_B = 17'h00C00;
  localparam logic [16:0] M_IORD = 17'h00200, M_REQ = 17'h00100, M_WE = 17'h00080;
  localparam logic [16:0] M_IR = 17'h00040, M_PCL = 17'h00020, M_PCS = 17'h00018;
  localparam logic [16:0] M_RA = 17'h00004, M_RD = 17'h00002, M_EN = 17'h00001;
  localparam logic [16:0] M_ENS = M_REQ | M_WE | M_IR | M_PCL | M_EN;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] i_opcode = '0, i_funct = '0;
  logic       i_alu_zero = 1'b0, i_mem_ready = 1'b0;
  logic [3:0] o_alu_op;
  logic       o_alu_src_a, o_iord, o_mem_req, o_mem_we, o_ir_load, o_pc_load;
  logic [1:0] o_alu_src_b, o_pc_src;
  logic       o_rd_addr_sel, o_rd_data_sel, o_rd_en, o_bus_err;
  logic [16:0] w_outs;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_opcode     (i_opcode),
    .i_funct      (i_funct),
    .i_alu_zero   (i_alu_zero),
    .i_mem_ready  (i_mem_ready),
    .o_alu_op     (o_alu_op),
    .o_alu_src_a  (o_alu_src_a),
    .o_alu_src_b  (o_alu_src_b),
    .o_iord       (o_iord),
    .o_mem_req    (o_mem_req),
    .o_mem_we     (o_mem_we),
    .o_ir_load    (o_ir_load),
    .o_pc_load    (o_pc_load),
    .o_pc_src     (o_pc_src),
    .o_rd_addr_sel(o_rd_addr_sel),
    .o_rd_data_sel(o_rd_data_sel),
    .o_rd_en      (o_rd_en),
    .o_bus_err    (o_bus_err)
  );

  assign w_outs = {o_alu_op, o_alu_src_a, o_alu_src_b, o_iord, o_mem_req, o_mem_we, o_ir_load,
                   o_pc_load, o_pc_src, o_rd_addr_sel, o_rd_data_sel, o_rd_en};

  typedef struct {
    logic [16:0] val;
    logic [16:0] care;
    logic        rdy;
    logic        zero;
    logic        err;
    logic [5:0]  op;
    logic [5:0]  fn;
    string       name;
  } rec_t;

  rec_t       exp_q[$];
  rec_t       r;
  logic [5:0] cur_op, cur_fn;
  logic       err_pend = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;

  function automatic logic [16:0] fop(input logic [3:0] op);
    return {op, 13'b0};
  endfunction
  function automatic logic [16:0] fb(input logic [1:0] b);
    return {5'b0, b, 10'b0};
  endfunction
  function automatic logic [16:0] fpcs(input logic [1:0] s);
    return {12'b0, s, 3'b0};
  endfunction
  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] funct_op(input logic [5:0] fn);
    case (fn)
      6'h20:   return A_ADD;
      6'h22:   return A_SUB;
      6'h24:   return A_AND;
      6'h25:   return A_OR;
      6'h2A:   return A_SLT;
      default: return A_AND;
    endcase
  endfunction

  function automatic void push(input logic [16:0] v, input logic [16:0] c, input logic rdy,
                               input logic zero, input logic err, input string nm);
    rec_t e;
    e.val = v; e.care = c; e.rdy = rdy; e.zero = zero; e.err = err;
    e.op = cur_op; e.fn = cur_fn; e.name = nm;
    exp_q.push_back(e);
  endfunction

  // A memory access with w stall cycles; more than MEM_TO stalls ends in a timeout.
  task automatic mem_phase(input logic [16:0] v, input logic [16:0] c, input logic [16:0] dv,
                           input logic [16:0] dc, input int w, input string nm, output bit to);
    to = (w > MEM_TO);
    for (int i = 0; i < (to ? MEM_TO + 1 : w); i++)
      push(v, c, 1'b0, rb(), to && (i == MEM_TO), nm);
    if (!to) push(v | dv, c | dc, 1'b1, rb(), 1'b0, {nm, "_done"});
  endtask

  // zsel: 0/1 force alu_zero in BRANCH, anything else randomizes it.
  task automatic add_instr(input logic [5:0] op, input logic [5:0] fn, input int wf,
                           input int wm, input int zsel);
    bit   to;
    logic z, legal;
    cur_op = op; cur_fn = fn;
    mem_phase(fop(A_ADD) | fb(2'd1) | M_REQ, M_ENS | M_OP | M_A | M_B | M_IORD,
              M_IR | M_PCL, M_PCS, wf, "fetch", to);
    if (to) return;
    legal = (op == OP_R) || (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ);
`ifdef CONTROL_JUMP_EN
    legal = legal || (op == OP_J);
`endif
    push(fop(A_ADD) | fb(2'd3), M_ENS | M_OP | M_A | M_B, rb(), rb(), !legal, "decode");
    case (op)
      OP_R: begin
        push(fop(funct_op(fn)) | M_A, M_ENS | M_OP | M_A | M_B, rb(), rb(), 1'b0, "exec");
        push(M_EN | M_RA, M_ENS | M_RA | M_RD, rb(), rb(), 1'b0, "aluwb");
      end
      OP_ADDI: begin
        push(fop(A_ADD) | M_A | fb(2'd2), M_ENS | M_OP | M_A | M_B, rb(), rb(), 1'b0, "iexec");
        push(M_EN, M_ENS | M_RA | M_RD, rb(), rb(), 1'b0, "iwb");
      end
      OP_LW: begin
        push(fop(A_ADD) | M_A | fb(2'd2), M_ENS | M_OP | M_A | M_B, rb(), rb(), 1'b0, "memadr");
        mem_phase(M_REQ | M_IORD, M_ENS | M_IORD, '0, '0, wm, "memrd", to);
        if (!to) push(M_EN | M_RD, M_ENS | M_RA | M_RD, rb(), rb(), 1'b0, "memwb");
      end
      OP_SW: begin
        push(fop(A_ADD) | M_A | fb(2'd2), M_ENS | M_OP | M_A | M_B, rb(), rb(), 1'b0, "memadr");
        mem_phase(M_REQ | M_WE | M_IORD, M_ENS | M_IORD, '0, '0, wm, "memwr", to);
      end
      OP_BEQ: begin
        z = (zsel == 0) ? 1'b0 : (zsel == 1) ? 1'b1 : rb();
        push(fop(A_SUB) | M_A | fpcs(2'd1) | (z ? M_PCL : '0),
             M_ENS | M_OP | M_A | M_B | M_PCS, rb(), z, 1'b0, "branch");
      end
`ifdef CONTROL_JUMP_EN
      OP_J: push(M_PCL | fpcs(2'd2), M_ENS | M_PCS, rb(), rb(), 1'b0, "jump");
`endif
      default: ;
    endcase
  endtask

  task automatic apply_reset();
    i_mem_ready = 1'b0; i_alu_zero = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    err_pend = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    i_mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    n_checks++;
    if ({o_mem_req, o_iord, o_mem_we, o_rd_en, o_ir_load, o_pc_load, o_bus_err} !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_state: req/iord/we/rd_en/ir/pc/err=%b want 1000000",
               {o_mem_req, o_iord, o_mem_we, o_rd_en, o_ir_load, o_pc_load, o_bus_err});
    end
    apply_reset();
    // Walk into MEMWR with the write stalled, then yank reset mid-access
    add_instr(OP_SW, 6'h00, 0, 99, 2);
    for (int k = 0; k < 6; k++) begin
      r = exp_q.pop_front();
      @(negedge clk);
      i_opcode = r.op; i_funct = r.fn; i_mem_ready = r.rdy; i_alu_zero = r.zero;
      #2;
      n_checks++;
      if ((((w_outs ^ r.val) & r.care) !== '0) || (o_bus_err !== err_pend)) begin
        n_fail++;
        $display("FAIL %s: got outs=%h bus_err=%b, want %h (care %h) bus_err=%b",
                 r.name, w_outs, o_bus_err, r.val, r.care, err_pend);
      end
      err_pend = r.err;
    end
    @(negedge clk);
    rst_n = 1'b0; i_mem_ready = 1'b0;
    #2;
    n_checks++;
    if ({o_mem_req, o_iord, o_mem_we, o_rd_en, o_bus_err} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_mid_memwr: req/iord/we/rd_en/err=%b want 10000",
               {o_mem_req, o_iord, o_mem_we, o_rd_en, o_bus_err});
    end
    @(negedge clk);
    #2;
    n_checks++;
    if ({o_mem_req, o_iord, o_mem_we, o_rd_en, o_bus_err} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_next_cycle: req/iord/we/rd_en/err=%b want 10000",
               {o_mem_req, o_iord, o_mem_we, o_rd_en, o_bus_err});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    err_pend = 1'b0;
    exp_q.delete();
    add_instr(OP_ADDI, 6'h00, 1, 0, 2);
    while (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      @(negedge clk);
      i_opcode = r.op; i_funct = r.fn; i_mem_ready = r.rdy; i_alu_zero = r.zero;
      #2;
      n_checks++;
      if ((((w_outs ^ r.val) & r.care) !== '0) || (o_bus_err !== err_pend)) begin
        n_fail++;
        $display("FAIL %s: got outs=%h bus_err=%b, want %h (care %h) bus_err=%b",
                 r.name, w_outs, o_bus_err, r.val, r.care, err_pend);
      end
      err_pend = r.err;
    end
  endtask

  task automatic test_rtype_lw_beq();
    apply_reset();
    add_instr(OP_R, 6'h22, 0, 0, 2);
    add_instr(OP_LW, 6'h00, 0, 3, 2);
    add_instr(OP_BEQ, 6'h00, 0, 0, 1);
    add_instr(OP_BEQ, 6'h00, 2, 0, 0);
    add_instr(OP_SW, 6'h00, 0, 0, 2);
    while (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      @(negedge clk);
      i_opcode = r.op; i_funct = r.fn; i_mem_ready = r.rdy; i_alu_zero = r.zero;
      #2;
      n_checks++;
      if ((((w_outs ^ r.val) & r.care) !== '0) || (o_bus_err !== err_pend)) begin
        n_fail++;
        $display("FAIL %s: got outs=%h bus_err=%b, want %h (care %h) bus_err=%b",
                 r.name, w_outs, o_bus_err, r.val, r.care, err_pend);
      end
      err_pend = r.err;
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    add_instr(OP_SW, 6'h00, 0, 99, 2);   // write never acknowledged
    add_instr(OP_LW, 6'h00, 0, 15, 2);   // ready arrives on the timeout cycle
    add_instr(OP_ADDI, 6'h00, 99, 0, 2); // fetch never acknowledged
    add_instr(OP_R, 6'h25, 0, 0, 2);
    while (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      @(negedge clk);
      i_opcode = r.op; i_funct = r.fn; i_mem_ready = r.rdy; i_alu_zero = r.zero;
      #2;
      n_checks++;
      if ((((w_outs ^ r.val) & r.care) !== '0) || (o_bus_err !== err_pend)) begin
        n_fail++;
        $display("FAIL %s: got outs=%h bus_err=%b, want %h (care %h) bus_err=%b",
                 r.name, w_outs, o_bus_err, r.val, r.care, err_pend);
      end
      err_pend = r.err;
    end
  endtask

  task automatic test_opcode_02();
    apply_reset();
    add_instr(OP_J, 6'h00, 0, 0, 2);
    add_instr(6'h3F, 6'h00, 0, 0, 2);
    add_instr(OP_R, 6'h2A, 0, 0, 2);
    while (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      @(negedge clk);
      i_opcode = r.op; i_funct = r.fn; i_mem_ready = r.rdy; i_alu_zero = r.zero;
      #2;
      n_checks++;
      if ((((w_outs ^ r.val) & r.care) !== '0) || (o_bus_err !== err_pend)) begin
        n_fail++;
        $display("FAIL %s: got outs=%h bus_err=%b, want %h (care %h) bus_err=%b",
                 r.name, w_outs, o_bus_err, r.val, r.care, err_pend);
      end
      err_pend = r.err;
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] op, fn;
    int         wf, wm;
    logic [5:0] fns[6];
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
    apply_reset();
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 7))
        0, 7:    op = OP_R;
        1:       op = OP_ADDI;
        2:       op = OP_LW;
        3:       op = OP_SW;
        4:       op = OP_BEQ;
        5:       op = OP_J;
        default: op = 6'($urandom_range(9, 34));
      endcase
      fn = fns[$urandom_range(0, 5)];
      if (fn == 6'h00) fn = 6'($urandom_range(0, 63));
      wf = ($urandom_range(0, 15) == 0) ? 16 : ($urandom_range(0, 7) == 0) ? 15
         : int'($urandom_range(0, 3));
      wm = ($urandom_range(0, 9) == 0) ? 16 : ($urandom_range(0, 7) == 0) ? 15
         : int'($urandom_range(0, 4));
      add_instr(op, fn, wf, wm, 2);
    end
    while (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      @(negedge clk);
      i_opcode = r.op; i_funct = r.fn; i_mem_ready = r.rdy; i_alu_zero = r.zero;
      #2;
      n_checks++;
      if ((((w_outs ^ r.val) & r.care) !== '0) || (o_bus_err !== err_pend)) begin
        n_fail++;
        $display("FAIL %s: got outs=%h bus_err=%b, want %h (care %h) bus_err=%b",
                 r.name, w_outs, o_bus_err, r.val, r.care, err_pend);
      end
      err_pend = r.err;
    end
  endtask

  initial begin
    test_reset();
    test_rtype_lw_beq();
    test_timeout();
    test_opcode_02();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
